// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : posit_pkg
// Description : Shared FP16 field geometry, posit limits and the state enum
//               of the posit serial transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package posit_pkg;

  localparam int c_fp16_w   = 16;
  localparam int c_exp_w    = 5;
  localparam int c_frac_w   = 10;
  localparam int c_exp_bias = 15;
  localparam int c_exp_max  = 31;
  localparam int c_max_prec = 8;
  localparam int c_prec_w   = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/posit_stream_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : posit_stream_tx_if
// Description : FP16 input handshake plus serial posit output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface posit_stream_tx_if #(
  parameter int ACT_WIDTH = posit_pkg::c_fp16_w
);

  logic                 in_valid;
  logic                 in_ready;
  logic [ACT_WIDTH-1:0] in_data;
  logic                 w;
  logic                 valid;
  logic                 last;
  logic                 busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, w, valid, last, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, w, valid, last, busy
  );

endinterface
`default_nettype wire

// File: rtl/posit_encoder.sv
`default_nettype none
// ============================================================================
// Module      : posit_encoder
// Description : Combinational FP16 -> n-bit sign-magnitude posit (es=0),
//               word left-aligned with the sign in the MSB.
//               Define POSIT_TX_ROUND_EN for round-to-nearest-even,
//               otherwise the magnitude truncates toward zero.
// Revision    : 1.0 - initial release
// ============================================================================
module posit_encoder
  import posit_pkg::*;
#(
  parameter int ACT_WIDTH = c_fp16_w,
  parameter int MAX_PREC  = c_max_prec
) (
  input  logic [ACT_WIDTH-1:0] fp_in,
  input  logic [c_prec_w-1:0]  prec,
  output logic [MAX_PREC-1:0]  word
);

  localparam int c_mag_w = MAX_PREC - 1;
  localparam int c_str_w = 32;

  logic               w_sign;
  logic [c_exp_w-1:0] w_exp;
  logic [c_frac_w-1:0] w_frac;
  logic [c_str_w-1:0] w_str;
  logic [c_mag_w-1:0] w_mask;
  logic [c_mag_w-1:0] w_ulp;
  logic [c_mag_w-1:0] w_trunc;
  logic [c_mag_w-1:0] w_mag;
  logic               w_guard;
  logic               w_sticky;
  int                 w_e;
  int                 w_m;

  assign w_sign = fp_in[ACT_WIDTH-1];
  assign w_exp  = fp_in[c_frac_w +: c_exp_w];
  assign w_frac = fp_in[c_frac_w-1:0];

  always_comb begin
    w_m = int'(prec) - 1;
    w_e = int'(w_exp) - c_exp_bias;
    // Regime run plus terminator, then the fraction, as one MSB-first bit string.
    if (w_e >= 0) begin
      w_str = ~({c_str_w{1'b1}} >> (w_e + 1))
            | ({w_frac, {(c_str_w-c_frac_w){1'b0}}} >> (w_e + 2));
    end else begin
      w_str = ({1'b1, {(c_str_w-1){1'b0}}} >> (-w_e))
            | ({w_frac, {(c_str_w-c_frac_w){1'b0}}} >> (1 - w_e));
    end
    w_mask   = ~({c_mag_w{1'b1}} >> w_m);
    w_ulp    = {{(c_mag_w-1){1'b0}}, 1'b1} << (c_mag_w - w_m);
    w_trunc  = w_str[c_str_w-1 -: c_mag_w] & w_mask;
    w_guard  = |(w_str & ({1'b1, {(c_str_w-1){1'b0}}} >> w_m));
    w_sticky = |(w_str << (w_m + 1));
    w_mag    = w_trunc;
`ifdef POSIT_TX_ROUND_EN
    // An all-ones magnitude is maxpos and must not wrap.
    if (w_guard && (w_sticky || (|(w_trunc & w_ulp))) && (w_trunc != w_mask)) begin
      w_mag = w_trunc + w_ulp;
    end
`endif
    if (w_mag == '0) begin
      w_mag = w_ulp;
    end
    if (w_exp == '0) begin
      word = '0;
    end else if (w_exp == c_exp_w'(c_exp_max)) begin
      word = {1'b1, {c_mag_w{1'b0}}};
    end else begin
      word = {w_sign, w_mag};
    end
  end

  // Without rounding the guard/sticky bits are intentionally unused.
  logic w_unused;
  assign w_unused = w_guard ^ w_sticky;

endmodule
`default_nettype wire

// File: rtl/posit_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : posit_stream_tx
// Description : Accepts FP16 words and shifts out n-bit posits MSB first.
//               Rounding mode selected by POSIT_TX_ROUND_EN in posit_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module posit_stream_tx
  import posit_pkg::*;
#(
  parameter int ACT_WIDTH = c_fp16_w,
  parameter int MAX_PREC  = c_max_prec
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set,
  input  logic [c_prec_w-1:0] precision,
  posit_stream_tx_if.slave    bus
);

  tx_state_t             r_state;
  logic [c_prec_w-1:0]   r_prec;
  logic [c_prec_w-1:0]   r_cnt;
  logic [MAX_PREC-1:0]   r_sreg;
  logic                  r_last;
  logic [MAX_PREC-1:0]   w_word;
  logic                  w_accept;

  posit_encoder #(
    .ACT_WIDTH (ACT_WIDTH),
    .MAX_PREC  (MAX_PREC)
  ) u_enc (
    .fp_in (bus.in_data),
    .prec  (r_prec),
    .word  (w_word)
  );

  assign bus.in_ready = (r_state == ST_IDLE) | ((r_state == ST_SHIFT) & r_last);
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign bus.w        = r_sreg[MAX_PREC-1];
  assign bus.valid    = (r_state == ST_SHIFT);
  assign bus.busy     = (r_state == ST_SHIFT);
  assign bus.last     = r_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_prec  <= c_prec_w'(MAX_PREC);
      r_cnt   <= '0;
      r_sreg  <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (set) begin
            r_prec <= precision;
          end
          if (w_accept) begin
            r_state <= ST_SHIFT;
            r_sreg  <= w_word;
            r_cnt   <= '0;
            r_last  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (r_last) begin
            if (w_accept) begin
              r_sreg <= w_word;
              r_cnt  <= '0;
              r_last <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_sreg  <= '0;
              r_last  <= 1'b0;
            end
          end else begin
            r_sreg <= r_sreg << 1;
            r_cnt  <= r_cnt + 1'b1;
            // Next bit shown is bit n-1 when the advanced count reaches n-1.
            r_last <= ((r_cnt + c_prec_w'(2)) == r_prec);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_posit_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_posit_stream_tx
// Description : Self-checking bench for posit_stream_tx against a real-valued
//               posit reference model (honours POSIT_TX_ROUND_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_posit_stream_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       set = 1'b0;
  logic [3:0] precision = 4'd8;
  int         n_tests = 0;
  int         n_fail  = 0;

  posit_stream_tx_if #(.ACT_WIDTH(16)) bus ();

  posit_stream_tx #(.ACT_WIDTH(16), .MAX_PREC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .set       (set),
    .precision (precision),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          n;
    int          expw;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  // Value of an m-bit es=0 posit magnitude pattern p (p > 0).
  function automatic real posit_val(input int p, input int m);
    int first, run, k, pos, fb, f;
    first = (p >> (m - 1)) & 1;
    run = 0;
    pos = m - 1;
    while (pos >= 0 && ((p >> pos) & 1) == first) begin
      run++;
      pos--;
    end
    k = (first == 1) ? run - 1 : -run;
    pos--;
    fb = (pos >= 0) ? pos + 1 : 0;
    f  = (fb > 0) ? (p & ((1 << fb) - 1)) : 0;
    return pow2(k) * (1.0 + real'(f) / pow2(fb));
  endfunction

  function automatic int ref_encode(input logic [15:0] d, input int n);
    int  m, ex, lo, best, maxp;
    real v, dl, dh;
    m    = n - 1;
    maxp = (1 << m) - 1;
    ex   = int'(d[14:10]);
    if (ex == 0)  return 0;
    if (ex == 31) return 1 << (n - 1);
    v  = pow2(ex - 15) * (1.0 + real'(d[9:0]) / 1024.0);
    lo = 0;
    for (int p = 1; p <= maxp; p++) if (posit_val(p, m) <= v) lo = p;
    dl = 0.0;
    dh = 0.0;
    if (lo == 0)         best = 1;
    else if (lo == maxp) best = maxp;
    else begin
`ifdef POSIT_TX_ROUND_EN
      dl = v - posit_val(lo, m);
      dh = posit_val(lo + 1, m) - v;
      best = (dh < dl || (dh == dl && (lo & 1) == 1)) ? lo + 1 : lo;
`else
      best = lo;
`endif
    end
    return (int'(d[15]) << (n - 1)) | best;
  endfunction

  task automatic set_prec(input int n);
    set = 1'b1;
    precision = 4'(n);
    @(negedge clk);
    set = 1'b0;
    precision = 4'($urandom_range(0, 15));
  endtask

  task automatic capture(input int n, input string nm, output int word);
    word = 0;
    for (int i = 0; i < n; i++) begin
      chk({nm, " valid"}, bus.valid, 1);
      chk({nm, " busy"}, bus.busy, 1);
      chk({nm, " last"}, bus.last, (i == n - 1));
      word = (word << 1) | int'(bus.w);
      @(negedge clk);
    end
    chk({nm, " valid after word"}, bus.valid, 0);
  endtask

  task automatic send_one(input logic [15:0] d, input int n, input string nm, output int got);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    chk({nm, " in_ready idle"}, bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
    capture(n, nm, got);
    chk({nm, " word"}, got, ref_encode(d, n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   got, wa, wb;
    logic [15:0] da, db;

    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset valid", bus.valid, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset last", bus.last, 0);
    chk("reset w", bus.w, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", bus.in_ready, 1);

    // Default precision is MAX_PREC
    send_one(16'h3C00, 8, "default prec", got);
    chk("default prec const", got, 32'h40);

    vecs.push_back('{16'h3C00, 8, 32'h40});
    vecs.push_back('{16'hBE00, 8, 32'hD0});
    vecs.push_back('{16'h3400, 8, 32'h10});
    vecs.push_back('{16'h6400, 8, 32'h7F});
    vecs.push_back('{16'h7C00, 8, 32'h80});
    vecs.push_back('{16'h0000, 8, 32'h00});
    vecs.push_back('{16'h8001, 8, 32'h00});
    vecs.push_back('{16'h0400, 8, 32'h01});
    vecs.push_back('{16'hFC00, 8, 32'h80});
    vecs.push_back('{16'h3C00, 3, 32'h2});
`ifdef POSIT_TX_ROUND_EN
    vecs.push_back('{16'h3F00, 4, 32'h6});
`else
    vecs.push_back('{16'h3F00, 4, 32'h5});
`endif
    foreach (vecs[i]) begin
      set_prec(vecs[i].n);
      send_one(vecs[i].data, vecs[i].n, $sformatf("vec%0d", i), got);
      chk($sformatf("vec%0d const", i), got, vecs[i].expw);
    end

    // Back-to-back words; a set pulse during SHIFT must be ignored
    set_prec(8);
    da = 16'hBE00;
    db = 16'h4A40;
    bus.in_valid = 1'b1;
    bus.in_data  = da;
    @(negedge clk);
    bus.in_data = db;
    wa = 0;
    wb = 0;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("b2b valid c%0d", c), bus.valid, 1);
      chk($sformatf("b2b in_ready c%0d", c), bus.in_ready, (c == 7 || c == 15));
      chk($sformatf("b2b last c%0d", c), bus.last, (c == 7 || c == 15));
      if (c < 8) wa = (wa << 1) | int'(bus.w);
      else       wb = (wb << 1) | int'(bus.w);
      if (c == 3) begin
        set = 1'b1;
        precision = 4'd4;
      end else begin
        set = 1'b0;
      end
      if (c == 8) bus.in_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b valid after", bus.valid, 0);
    chk("b2b word a", wa, ref_encode(da, 8));
    chk("b2b word b", wb, ref_encode(db, 8));

    // Reset at bit 3 of a word in flight
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h3C00;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset valid", bus.valid, 1);
    rst = 1'b0;
    #1;
    chk("mid reset valid", bus.valid, 0);
    chk("mid reset busy", bus.busy, 0);
    chk("mid reset w", bus.w, 0);
    @(negedge clk);
    rst = 1'b1;
    set_prec(5);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("post reset idle valid c%0d", c), bus.valid, 0);
      @(negedge clk);
    end
    send_one(16'h3C00, 5, "n5 word", got);
    chk("n5 const", got, 32'h08);

    // Randomised words at random precision
    for (int i = 0; i < 150; i++) begin
      int n;
      logic [15:0] d;
      n = int'($urandom_range(3, 8));
      d = 16'($urandom);
      set_prec(n);
      send_one(d, n, $sformatf("rand%0d n%0d d%04h", i, n, d), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
